// File: rtl/ysyx_23060184_axi_pkg.sv
// Shared AXI-lite definitions for the SRAM slave: widths, response codes,
// FSM state encodings and the address-decode helpers.
package ysyx_23060184_axi_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = 4;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_RESP
   } r_state_t;

   typedef enum logic [2:0] {
      W_IDLE,
      W_HAVE_AW,
      W_HAVE_W,
      W_WAIT,
      W_RESP
   } w_state_t;

   // Word offset from the base; the two byte-offset bits are simply dropped.
   function automatic logic [ADDR_W-1:0] word_offset(input logic [ADDR_W-1:0] addr,
                                                     input logic [ADDR_W-1:0] base);
      return (addr - base) >> 2;
   endfunction

   function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input int unsigned       depth);
      return (addr >= base) && (word_offset(addr, base) < depth);
   endfunction

endpackage

// File: rtl/ysyx_23060184_sram_array.sv
// Word storage: one synchronous read port and one byte-enable write port.
// Contents are never reset; a read and write to the same word return old data.
module ysyx_23060184_sram_array
   import ysyx_23060184_axi_pkg::*;
#(
   parameter int unsigned DEPTH = 1024,
   parameter int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [STRB_W-1:0] wr_strb
);

   // One byte-wide memory per lane keeps each lane a plain RAM with its own enable.
   for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_q;

      always_ff @(posedge clk) begin
         if (wr_en && wr_strb[gi]) begin
            lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
         end
         if (rd_en) begin
            lane_q <= lane_mem[rd_idx];
         end
      end

      assign rd_data[gi*8 +: 8] = lane_q;
   end

endmodule

// File: rtl/ysyx_23060184_sram_slave.sv
// AXI-lite SRAM slave with independent read and write FSMs, programmable
// response latency and DECERR for addresses outside the mapped window.
module ysyx_23060184_sram_slave
   import ysyx_23060184_axi_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned       DEPTH_WORDS = 1024,
   parameter int unsigned       RD_LAT      = 2,
   parameter int unsigned       WR_LAT      = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [ADDR_W-1:0] araddr,
   input  logic              arvalid,
   output logic              arready,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        rresp,
   output logic              rvalid,
   input  logic              rready,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic              awvalid,
   output logic              awready,
   input  logic [DATA_W-1:0] wdata,
   input  logic [STRB_W-1:0] wstrb,
   input  logic              wvalid,
   output logic              wready,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready
);

   localparam int              IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT);

   r_state_t            r_state_reg, r_state_next;
   logic [CNT_W-1:0]    r_cnt_reg, r_cnt_next;
   logic                r_ok_reg;
   logic [IDX_W-1:0]    r_idx_reg;
   logic                rd_en;
   logic [DATA_W-1:0]   rd_q;

   w_state_t            w_state_reg, w_state_next;
   logic [CNT_W-1:0]    w_cnt_reg, w_cnt_next;
   logic                w_ok_reg;
   logic [IDX_W-1:0]    w_idx_reg;
   logic [DATA_W-1:0]   w_data_reg;
   logic [STRB_W-1:0]   w_strb_reg;
   logic                wr_en;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state_reg <= R_IDLE;
         r_cnt_reg   <= '0;
         w_state_reg <= W_IDLE;
         w_cnt_reg   <= '0;
      end else begin
         r_state_reg <= r_state_next;
         r_cnt_reg   <= r_cnt_next;
         w_state_reg <= w_state_next;
         w_cnt_reg   <= w_cnt_next;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ok_reg   <= 1'b0;
         r_idx_reg  <= '0;
         w_ok_reg   <= 1'b0;
         w_idx_reg  <= '0;
         w_data_reg <= '0;
         w_strb_reg <= '0;
      end else begin
         if (arvalid && arready) begin
            r_ok_reg  <= addr_hit(araddr, BASE_ADDR, DEPTH_WORDS);
            r_idx_reg <= IDX_W'(word_offset(araddr, BASE_ADDR));
         end
         if (awvalid && awready) begin
            w_ok_reg  <= addr_hit(awaddr, BASE_ADDR, DEPTH_WORDS);
            w_idx_reg <= IDX_W'(word_offset(awaddr, BASE_ADDR));
         end
         if (wvalid && wready) begin
            w_data_reg <= wdata;
            w_strb_reg <= wstrb;
         end
      end
   end

   always_comb begin
      r_state_next = r_state_reg;
      r_cnt_next   = r_cnt_reg;
      arready      = 1'b0;
      rvalid       = 1'b0;
      rd_en        = 1'b0;
      unique case (r_state_reg)
         R_IDLE: begin
            arready = 1'b1;
            if (arvalid) begin
               r_state_next = R_WAIT;
               r_cnt_next   = RD_LOAD;
            end
         end
         R_WAIT: begin
            if (r_cnt_reg == '0) begin
               rd_en        = r_ok_reg;
               r_state_next = R_RESP;
            end else begin
               r_cnt_next = r_cnt_reg - CNT_W'(1);
            end
         end
         R_RESP: begin
            rvalid = 1'b1;
            if (rready) begin
               r_state_next = R_IDLE;
            end
         end
         default: r_state_next = R_IDLE;
      endcase
   end

   always_comb begin
      w_state_next = w_state_reg;
      w_cnt_next   = w_cnt_reg;
      awready      = 1'b0;
      wready       = 1'b0;
      bvalid       = 1'b0;
      wr_en        = 1'b0;
      unique case (w_state_reg)
         W_IDLE: begin
            awready = 1'b1;
            wready  = 1'b1;
            if (awvalid && wvalid) begin
               w_state_next = W_WAIT;
               w_cnt_next   = WR_LOAD;
            end else if (awvalid) begin
               w_state_next = W_HAVE_AW;
            end else if (wvalid) begin
               w_state_next = W_HAVE_W;
            end
         end
         W_HAVE_AW: begin
            wready = 1'b1;
            if (wvalid) begin
               w_state_next = W_WAIT;
               w_cnt_next   = WR_LOAD;
            end
         end
         W_HAVE_W: begin
            awready = 1'b1;
            if (awvalid) begin
               w_state_next = W_WAIT;
               w_cnt_next   = WR_LOAD;
            end
         end
         W_WAIT: begin
            if (w_cnt_reg == '0) begin
               wr_en        = w_ok_reg;
               w_state_next = W_RESP;
            end else begin
               w_cnt_next = w_cnt_reg - CNT_W'(1);
            end
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (bready) begin
               w_state_next = W_IDLE;
            end
         end
         default: w_state_next = W_IDLE;
      endcase
   end

   // The array's read register only moves on rd_en, so rdata stays put while waiting for rready.
   assign rdata = (rvalid && r_ok_reg) ? rd_q : '0;
   assign rresp = (rvalid && !r_ok_reg) ? RESP_DECERR : RESP_OKAY;
   assign bresp = (bvalid && !w_ok_reg) ? RESP_DECERR : RESP_OKAY;

   ysyx_23060184_sram_array #(
      .DEPTH (DEPTH_WORDS),
      .IDX_W (IDX_W)
   ) u_array (
      .clk     (clk),
      .rd_en   (rd_en),
      .rd_idx  (r_idx_reg),
      .rd_data (rd_q),
      .wr_en   (wr_en),
      .wr_idx  (w_idx_reg),
      .wr_data (w_data_reg),
      .wr_strb (w_strb_reg)
   );

endmodule

// File: tb/tb_ysyx_23060184_sram_slave.sv
// Directed bench for the SRAM slave: a transaction-level memory/latency model
// checked every cycle, plus hand-computed expectations for key scenarios.
module tb_ysyx_23060184_sram_slave;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 1024;
   localparam int          RDL   = 2;
   localparam int          WRL   = 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic [31:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b1;
   logic [31:0] awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b1;

   always #5 clk = ~clk;

   ysyx_23060184_sram_slave #(
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (DEPTH),
      .RD_LAT      (RDL),
      .WR_LAT      (WRL)
   ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .araddr  (araddr),
      .arvalid (arvalid),
      .arready (arready),
      .rdata   (rdata),
      .rresp   (rresp),
      .rvalid  (rvalid),
      .rready  (rready),
      .awaddr  (awaddr),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wvalid  (wvalid),
      .wready  (wready),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int edge_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   logic [31:0] mdl_mem [int];
   bit          rd_pend, exp_rvalid, exp_rknown, r_hs_pend;
   int          rd_due;
   logic [31:0] rd_addr, exp_rdata;
   logic [1:0]  exp_rresp;
   bit          have_aw, have_w, wr_pend, exp_bvalid, b_hs_pend;
   int          wr_due;
   logic [31:0] aw_addr, w_data, wr_addr, wr_data;
   logic [3:0]  w_strb, wr_strb;
   logic [1:0]  exp_bresp;

   function automatic bit in_range(input logic [31:0] a);
      if (a < BASE) return 1'b0;
      return ((a - BASE) / 4) < DEPTH;
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - BASE) / 4);
   endfunction

   initial forever begin
      @(posedge clk);
      edge_cnt++;
   end

   initial forever begin
      @(negedge clk);
      if (!resetn) begin
         rd_pend = 0; exp_rvalid = 0; r_hs_pend = 0;
         have_aw = 0; have_w = 0; wr_pend = 0; exp_bvalid = 0; b_hs_pend = 0;
         chk("rst_arready", arready, 1);
         chk("rst_awready", awready, 1);
         chk("rst_wready", wready, 1);
         chk("rst_rvalid", rvalid, 0);
         chk("rst_bvalid", bvalid, 0);
      end else begin
         if (r_hs_pend) begin exp_rvalid = 0; r_hs_pend = 0; end
         if (b_hs_pend) begin exp_bvalid = 0; b_hs_pend = 0; end
         // Read sample happens before a same-edge commit, so the reader sees old data.
         if (rd_pend && rd_due == edge_cnt) begin
            rd_pend = 0;
            exp_rvalid = 1;
            if (in_range(rd_addr)) begin
               exp_rresp  = 2'b00;
               exp_rknown = mdl_mem.exists(widx(rd_addr));
               exp_rdata  = exp_rknown ? mdl_mem[widx(rd_addr)] : 32'h0;
            end else begin
               exp_rresp  = 2'b11;
               exp_rknown = 1;
               exp_rdata  = 32'h0;
            end
         end
         if (wr_pend && wr_due == edge_cnt) begin
            wr_pend = 0;
            exp_bvalid = 1;
            if (in_range(wr_addr)) begin
               exp_bresp = 2'b00;
               if (mdl_mem.exists(widx(wr_addr))) begin
                  logic [31:0] w;
                  w = mdl_mem[widx(wr_addr)];
                  for (int b = 0; b < 4; b++)
                     if (wr_strb[b]) w[b*8 +: 8] = wr_data[b*8 +: 8];
                  mdl_mem[widx(wr_addr)] = w;
               end else if (wr_strb == 4'hf) begin
                  mdl_mem[widx(wr_addr)] = wr_data;
               end
            end else begin
               exp_bresp = 2'b11;
            end
         end
         chk("m_rvalid", rvalid, exp_rvalid);
         if (exp_rvalid) begin
            chk("m_rresp", rresp, exp_rresp);
            if (exp_rknown) chk("m_rdata", rdata, exp_rdata);
         end
         chk("m_bvalid", bvalid, exp_bvalid);
         if (exp_bvalid) chk("m_bresp", bresp, exp_bresp);
         chk("m_arready", arready, !rd_pend && !exp_rvalid);
         chk("m_awready", awready, !have_aw && !wr_pend && !exp_bvalid);
         chk("m_wready", wready, !have_w && !wr_pend && !exp_bvalid);
         // Handshakes that complete at the coming rising edge.
         if (arvalid && arready) begin
            rd_pend = 1; rd_due = edge_cnt + 2 + RDL; rd_addr = araddr;
         end
         if (rvalid && rready) r_hs_pend = 1;
         if (awvalid && awready) begin have_aw = 1; aw_addr = awaddr; end
         if (wvalid && wready) begin have_w = 1; w_data = wdata; w_strb = wstrb; end
         if (have_aw && have_w) begin
            wr_pend = 1; wr_due = edge_cnt + 2 + WRL;
            wr_addr = aw_addr; wr_data = w_data; wr_strb = w_strb;
            have_aw = 0; have_w = 0;
         end
         if (bvalid && bready) b_hs_pend = 1;
      end
   end

   // ---------------- stimulus helpers (start and end at posedge+1) ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_ar(input logic [31:0] a);
      araddr = a;
      arvalid = 1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (arready) begin
            tick();
            arvalid = 0;
            $display("AR  addr=%h accepted", a);
            return;
         end
         tick();
      end
      arvalid = 0;
      n_cmp++; n_fail++;
      $display("FAIL ar_timeout: got no arready required arready for addr %h", a);
   endtask

   task automatic send_write(input bit do_aw, input bit do_w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
      bit aw_go, w_go;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = do_aw; wvalid = do_w;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         aw_go = awvalid && awready;
         w_go  = wvalid && wready;
         tick();
         if (aw_go) awvalid = 0;
         if (w_go) wvalid = 0;
         if (!awvalid && !wvalid) begin
            $display("WR  aw=%0d w=%0d addr=%h data=%h strb=%b accepted", do_aw, do_w, a, d, s);
            return;
         end
      end
      awvalid = 0; wvalid = 0;
      n_cmp++; n_fail++;
      $display("FAIL wr_timeout: got no ready required awready/wready for addr %h", a);
   endtask

   task automatic wait_r(output logic [31:0] d, output logic [1:0] r);
      d = 'x; r = 'x;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rvalid) begin
            d = rdata; r = rresp;
            tick();
            $display("R   data=%h resp=%b", d, r);
            return;
         end
         tick();
      end
      n_cmp++; n_fail++;
      $display("FAIL r_timeout: got no rvalid required rvalid");
   endtask

   task automatic wait_b(output logic [1:0] r);
      r = 'x;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bvalid) begin
            r = bresp;
            tick();
            $display("B   resp=%b", r);
            return;
         end
         tick();
      end
      n_cmp++; n_fail++;
      $display("FAIL b_timeout: got no bvalid required bvalid");
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r);
      send_write(1, 1, a, d, s);
      wait_b(r);
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
      send_ar(a);
      wait_r(d, r);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish required finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      logic [31:0] d;
      logic [1:0]  r;

      #1 resetn = 0;
      repeat (3) @(posedge clk);
      #1 resetn = 1;

      // Read latency and data after a full-word write.
      do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hf, r);
      chk("wr10_bresp", r, 2'b00);
      send_ar(32'h8000_0010);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rd_lat_rvalid", rvalid, (k == 3));
      end
      chk("rd_lat_rdata", rdata, 32'hDEAD_BEEF);
      chk("rd_lat_rresp", rresp, 2'b00);
      tick();

      // W two cycles ahead of AW, partial strobes, write latency.
      do_write(32'h8000_0020, 32'hFFFF_FFFF, 4'hf, r);
      send_write(0, 1, 32'h0, 32'h1122_3344, 4'b0101);
      tick();
      send_write(1, 0, 32'h8000_0020, 32'h0, 4'h0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("wr_lat_bvalid", bvalid, (k == 3));
      end
      chk("wr_lat_bresp", bresp, 2'b00);
      tick();
      do_read(32'h8000_0020, d, r);
      chk("strb_merge", d, 32'hFF22_FF44);

      // Out-of-range accesses and the last in-range word.
      do_write(32'h8000_0000, 32'hA5A5_0001, 4'hf, r);
      do_write(32'h8000_0FFC, 32'hCAFE_0000, 4'hf, r);
      chk("last_word_bresp", r, 2'b00);
      do_read(32'h7FFF_FFFC, d, r);
      chk("below_rresp", r, 2'b11);
      chk("below_rdata", d, 32'h0);
      do_write(32'h8000_1000, 32'h1234_5678, 4'hf, r);
      chk("above_bresp", r, 2'b11);
      do_read(32'h8000_0000, d, r);
      chk("word0_unchanged", d, 32'hA5A5_0001);
      do_read(32'h8000_0FFC, d, r);
      chk("last_word_rdata", d, 32'hCAFE_0000);

      // Back-pressure on R: everything holds, next AR goes the cycle after the handshake.
      rready = 0;
      send_ar(32'h8000_0010);
      for (int i = 0; i < 20 && !rvalid; i++) @(negedge clk);
      tick();
      araddr = 32'h8000_0020;
      arvalid = 1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold_rvalid", rvalid, 1);
         chk("hold_rdata", rdata, 32'hDEAD_BEEF);
         chk("hold_arready", arready, 0);
         tick();
      end
      rready = 1;
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("ar_after_hs", arready, 1);
      tick();
      arvalid = 0;
      wait_r(d, r);
      chk("ar_after_hs_data", d, 32'hFF22_FF44);

      // Same-edge read sample and write commit: reader gets old data.
      do_write(32'h8000_0040, 32'h0, 4'hf, r);
      araddr = 32'h8000_0040; arvalid = 1;
      awaddr = 32'h8000_0040; awvalid = 1;
      wdata = 32'h5; wstrb = 4'hf; wvalid = 1;
      @(negedge clk);
      chk("same_cycle_ready", {arready, awready, wready}, 3'b111);
      tick();
      arvalid = 0; awvalid = 0; wvalid = 0;
      for (int i = 0; i < 20 && !rvalid; i++) @(negedge clk);
      chk("same_cycle_rdata", rdata, 32'h0);
      chk("same_cycle_bvalid", bvalid, 1);
      tick();
      do_read(32'h8000_0040, d, r);
      chk("same_cycle_later", d, 32'h5);

      // Zero strobes and ignored byte offset.
      do_write(32'h8000_0010, 32'h0BAD_0BAD, 4'h0, r);
      chk("strb0_bresp", r, 2'b00);
      do_read(32'h8000_0013, d, r);
      chk("strb0_unaligned", d, 32'hDEAD_BEEF);

      // Reset in the middle of the write latency.
      send_write(1, 1, 32'h8000_0010, 32'h1111_1111, 4'hf);
      tick();
      resetn = 0;
      #1;
      chk("mid_rst_arready", arready, 1);
      chk("mid_rst_awready", awready, 1);
      chk("mid_rst_wready", wready, 1);
      chk("mid_rst_rvalid", rvalid, 0);
      chk("mid_rst_bvalid", bvalid, 0);
      chk("mid_rst_rresp", rresp, 0);
      chk("mid_rst_bresp", bresp, 0);
      chk("mid_rst_rdata", rdata, 0);
      repeat (2) @(posedge clk);
      #1 resetn = 1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("post_rst_bvalid", bvalid, 0);
      end
      tick();
      do_read(32'h8000_0010, d, r);
      chk("post_rst_word", d, 32'hDEAD_BEEF);

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_23060184_sram_slave.md
YSYX_23060184_SRAM_SLAVE -- requirements
Module: ysyx_23060184_sram_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, storage size in 32-bit words (power of two).
REQ-003 SHALL have parameter RD_LAT, default 2, cycles from AR accept to rvalid (0..15).
REQ-004 SHALL have parameter WR_LAT, default 2, cycles from AW+W both accepted to bvalid (0..15).
REQ-005 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port resetn  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have ports araddr in 32 / arvalid in 1 / arready out 1, read address channel.
REQ-008 SHALL have ports rdata out 32 / rresp out 2 / rvalid out 1 / rready in 1, read data channel.
REQ-009 SHALL have ports awaddr in 32 / awvalid in 1 / awready out 1, write address channel.
REQ-010 SHALL have ports wdata in 32 / wstrb in 4 / wvalid in 1 / wready out 1, write data channel.
REQ-011 SHALL have ports bresp out 2 / bvalid out 1 / bready in 1, write response channel.

Function
REQ-012 Handshake on any channel SHALL complete in a cycle where valid and ready are both high at the rising edge.
REQ-013 Read FSM SHALL have states R_IDLE, R_WAIT, R_RESP; arready=1 only in R_IDLE.
REQ-014 R_IDLE -> R_WAIT on AR handshake, latching araddr and loading latency counter with RD_LAT.
REQ-015 R_WAIT SHALL decrement counter each cycle; at zero, sample storage into rdata, set rvalid, -> R_RESP (RD_LAT=0: rvalid in cycle after accept).
REQ-016 R_RESP SHALL hold rdata, rresp, rvalid stable until R handshake, then -> R_IDLE; next AR accepted no earlier than the following cycle.
REQ-017 Write FSM SHALL have states W_IDLE, W_HAVE_AW, W_HAVE_W, W_WAIT, W_RESP; awready=1 in W_IDLE and W_HAVE_W, wready=1 in W_IDLE and W_HAVE_AW.
REQ-018 AW and W SHALL be accepted in either order or the same cycle; both held -> W_WAIT with counter=WR_LAT.
REQ-019 At counter zero in W_WAIT the write SHALL commit with byte enables wstrb (bit i -> byte i), set bvalid, -> W_RESP.
REQ-020 W_RESP SHALL hold bresp, bvalid until B handshake, then -> W_IDLE.
REQ-021 Word index SHALL be (addr - BASE_ADDR) >> 2; addr[1:0] ignored (no misalignment error).
REQ-022 Address below BASE_ADDR or index >= DEPTH_WORDS SHALL give resp 2'b11 (DECERR), rdata=0, no storage write.
REQ-023 In-range access SHALL give resp 2'b00 (OKAY).
REQ-024 Read and write channels SHALL operate independently and concurrently.
REQ-025 Read sample and write commit to the same word in the same cycle SHALL return old data to the reader.
REQ-026 wstrb=4'b0000 in range SHALL respond OKAY with storage unchanged.

Reset
REQ-027 On resetn low, SHALL immediately force R_IDLE, W_IDLE, rvalid=0, bvalid=0, rresp=0, bresp=0, rdata=0, counters=0, arready=1, awready=1, wready=1.
REQ-028 Reset mid-transaction SHALL abandon it with no storage write and no response after release.
REQ-029 Storage contents SHALL NOT be reset.

Structure
REQ-030 Shared package ysyx_23060184_axi_pkg SHALL hold resp codes (OKAY, DECERR), address/data/strobe widths, and FSM state encodings.
REQ-031 Storage SHALL be sub-module ysyx_23060184_sram_array: one sync-read port, one byte-enable write port, no reset.

Verification
REQ-032 AR 0x8000_0010 after write 0xDEAD_BEEF there, rready=1 -> rvalid exactly RD_LAT+1 cycles after accept, rdata=0xDEAD_BEEF, rresp=00.
REQ-033 W (0x1122_3344, wstrb=0101) two cycles before AW 0x8000_0020 on word 0xFFFF_FFFF -> bvalid WR_LAT+1 cycles after AW, bresp=00, readback 0xFF22_FF44.
REQ-034 AR 0x7FFF_FFFC and AW 0x8000_1000 (DEPTH 1024) -> rresp=11, rdata=0, bresp=11, storage unchanged.
REQ-035 Hold rready=0 for 5 cycles in R_RESP -> rvalid, rdata stable, arready=0 throughout; new AR accepted cycle after handshake.
REQ-036 Same-cycle read sample and write commit to 0x8000_0040 (old 0x0, new 0x5) -> rdata=0x0, later read 0x5.
REQ-037 Assert resetn=0 mid-W_WAIT -> outputs at reset values same cycle, no bvalid after release, target word unchanged.
